// File: rtl/uart_word_pkg.sv
// -----------------------------------------------------------------------------
// uart_word_pkg
// Shared definitions for the UART word receiver: bit-FSM state encoding,
// byte/word widths, the default bit period and the even-parity helper.
// Optional feature macro used by the including files: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
package uart_word_pkg;

    localparam int UART_BYTE_W           = 8;
    localparam int UART_WORD_W           = 16;
    // 100 MHz system clock / 115200 baud
    localparam int UART_CLKS_PER_BIT_DEF = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_word_rx_if.sv
// -----------------------------------------------------------------------------
// uart_word_rx_if
// Valid/ready word stream between the UART word receiver and its consumer.
//   data  : received 16-bit word, high byte first on the wire
//   valid : data holds an unconsumed word
//   ready : consumer accepts data when valid && ready at a rising edge
// Modports: master (word source), slave (word consumer).
// -----------------------------------------------------------------------------
interface uart_word_rx_if;
    import uart_word_pkg::*;

    logic [UART_WORD_W-1:0] data;
    logic                   valid;
    logic                   ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// Synchronises the serial input and deserialises 8N1 bytes (8E1 when
// UART_RX_PARITY_EN is defined).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_rx          : raw serial input, idle high, asynchronous to clk
//   o_byte        : last deserialised byte, valid while o_byte_valid is high
//   o_byte_valid  : one-cycle pulse, byte received with good stop (and parity)
//   o_byte_err    : one-cycle pulse, stop bit low or parity mismatch
//   o_busy        : a frame is in progress (FSM not idle)
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_word_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_rx,
    output logic [UART_BYTE_W-1:0] o_byte,
    output logic                   o_byte_valid,
    output logic                   o_byte_err,
    output logic                   o_busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_prev;
    uart_rx_state_e         r_state;
    uart_rx_state_e         w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_bit_cnt;
    logic [UART_BYTE_W-1:0] r_shift;
    logic                   r_par_ok;
    logic                   r_byte_valid;
    logic                   r_byte_err;

    logic w_tick_half;
    logic w_tick_full;
    logic w_fall;
    logic w_sample;
    logic w_stop_sample;
    logic w_byte_valid_nxt;
    logic w_byte_err_nxt;

    assign w_tick_half = (r_cnt == HALF_LAST);
    assign w_tick_full = (r_cnt == FULL_LAST);
    assign w_fall      = r_prev & ~r_sync2;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Bit FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bit FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_fall) w_state_next = START;
                else        w_state_next = IDLE;
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (w_tick_half) w_state_next = r_sync2 ? IDLE : DATA;
                else             w_state_next = START;
            end
            DATA: begin
                if (w_tick_full && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end else begin
                    w_state_next = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick_full) w_state_next = STOP;
                else             w_state_next = PARITY;
            end
`endif
            STOP: begin
                // Leave right after the mid-bit sample so a following start
                // edge inside the remaining stop half-bit is not missed.
                if (w_tick_full) w_state_next = IDLE;
                else             w_state_next = STOP;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bit FSM output decode: sample strobes and next byte status pulses.
    always_comb begin
        w_sample      = ((r_state == START) && w_tick_half) ||
                        (((r_state == DATA) || (r_state == PARITY) || (r_state == STOP)) && w_tick_full);
        w_stop_sample = (r_state == STOP) && w_tick_full;
        w_byte_valid_nxt = w_stop_sample &&  (r_sync2 && r_par_ok);
        w_byte_err_nxt   = w_stop_sample && !(r_sync2 && r_par_ok);
    end

    // Bit-period counter, bit index, shift register and parity result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_bit_cnt <= 3'd0;
            r_shift   <= {UART_BYTE_W{1'b0}};
            r_par_ok  <= 1'b1;
        end else begin
            if ((r_state == IDLE) || w_sample) r_cnt <= {CNT_W{1'b0}};
            else                               r_cnt <= r_cnt + CNT_W'(1);

            if (r_state == IDLE)                      r_bit_cnt <= 3'd0;
            else if ((r_state == DATA) && w_tick_full) r_bit_cnt <= r_bit_cnt + 3'd1;
            else                                       r_bit_cnt <= r_bit_cnt;

            // LSB first: new bits enter at the top and shift down.
            if ((r_state == DATA) && w_tick_full) r_shift <= {r_sync2, r_shift[UART_BYTE_W-1:1]};
            else                                  r_shift <= r_shift;

`ifdef UART_RX_PARITY_EN
            if (r_state == IDLE)                         r_par_ok <= 1'b1;
            else if ((r_state == PARITY) && w_tick_full) r_par_ok <= (r_sync2 == even_parity(r_shift));
            else                                         r_par_ok <= r_par_ok;
`else
            r_par_ok <= 1'b1;
`endif
        end
    end

    // Registered byte status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_valid <= 1'b0;
            r_byte_err   <= 1'b0;
        end else begin
            r_byte_valid <= w_byte_valid_nxt;
            r_byte_err   <= w_byte_err_nxt;
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_byte_err   = r_byte_err;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// -----------------------------------------------------------------------------
// uart_word_rx
// Receives UART bytes and pairs them into 16-bit words (high byte first),
// presented on a single-entry valid/ready output register.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit per byte).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   uart_rx     : serial input, idle high
//   word_if     : master side of the word stream (data, valid / ready)
//   frame_err   : one-cycle pulse on a bad stop bit (or parity error)
//   overrun     : sticky, a completed word was dropped; cleared by reset
// -----------------------------------------------------------------------------
module uart_word_rx
    import uart_word_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rx,
    uart_word_rx_if.master word_if,
    output logic           frame_err,
    output logic           overrun
);

    localparam int            TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TO_W      = $clog2(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic [UART_BYTE_W-1:0] w_byte;
    logic                   w_byte_valid;
    logic                   w_byte_err;
    logic                   w_busy;

    logic                   r_phase;
    logic [UART_BYTE_W-1:0] r_hi;
    logic [TO_W-1:0]        r_to_cnt;
    logic [UART_WORD_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_overrun;

    logic w_word_done;
    logic w_to_expire;
    logic w_load;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (uart_rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_byte_err   (w_byte_err),
        .o_busy       (w_busy)
    );

    // Word completion, timeout expiry and output-register load decisions.
    always_comb begin
        w_word_done = w_byte_valid && r_phase;
        // The timeout only runs while no frame is being received.
        w_to_expire = r_phase && !w_busy && !w_byte_valid && (r_to_cnt == TO_LAST);
        w_load      = w_word_done && (!r_valid || word_if.ready);
    end

    // Word assembler: high-byte store and phase tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_hi    <= {UART_BYTE_W{1'b0}};
        end else begin
            if (w_byte_valid && !r_phase) begin
                r_phase <= 1'b1;
                r_hi    <= w_byte;
            end else if (w_byte_valid || w_byte_err || w_to_expire) begin
                r_phase <= 1'b0;
                r_hi    <= r_hi;
            end else begin
                r_phase <= r_phase;
                r_hi    <= r_hi;
            end
        end
    end

    // Partial-word timeout counter; restarts whenever a frame is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            if (!r_phase || w_busy || w_byte_valid || w_to_expire) r_to_cnt <= {TO_W{1'b0}};
            else                                                    r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Single-entry output register with sticky overrun on a dropped word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= {UART_WORD_W{1'b0}};
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= {r_hi, w_byte};
                r_valid <= 1'b1;
            end else if (r_valid && word_if.ready) begin
                r_data  <= r_data;
                r_valid <= 1'b0;
            end else begin
                r_data  <= r_data;
                r_valid <= r_valid;
            end

            if (w_word_done && r_valid && !word_if.ready) r_overrun <= 1'b1;
            else                                          r_overrun <= r_overrun;
        end
    end

    assign word_if.data  = r_data;
    assign word_if.valid = r_valid;
    assign frame_err     = w_byte_err;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_word_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_word_rx
// Directed self-checking bench for uart_word_rx with CLKS_PER_BIT=16,
// TIMEOUT_BITS=20. Parity scenario is built when UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_word_rx;

    localparam int BIT = 16;

    logic clk;
    logic rst_n;
    logic uart_rx;
    logic frame_err;
    logic overrun;

    uart_word_rx_if u_if ();

    uart_word_rx #(
        .CLKS_PER_BIT (BIT),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .word_if   (u_if),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int checks   = 0;
    int failures = 0;

    // Monitor state (written only by the monitor processes)
    int          cyc     = 0;
    int          n_ferr  = 0;
    int          n_vrise = 0;
    int          n_words = 0;
    int          t_rise  = 0;
    logic        v_prev  = 1'b0;
    logic [15:0] words [0:63];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) n_ferr <= n_ferr + 1;
            if (u_if.valid && !v_prev) begin
                n_vrise <= n_vrise + 1;
                t_rise  <= cyc;
            end
            if (u_if.valid && u_if.ready && n_words < 64) begin
                words[n_words] <= u_if.data;
                n_words        <= n_words + 1;
            end
            v_prev <= u_if.valid;
        end else begin
            v_prev <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int nbits);
        uart_rx = 1'b1;
        repeat (nbits * BIT) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) tick();
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = ^b;
        repeat (BIT) tick();
`endif
        uart_rx = stop_bit;
        repeat (BIT) tick();
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        uart_rx   = 1'b1;
        u_if.ready = 1'b1;
        repeat (5) tick();
        checks++; if (u_if.data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", u_if.data); end
        checks++; if (u_if.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", u_if.valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_basic();
        int bw, bv, bf, t0, lat, nom;
        bw = n_words; bv = n_vrise; bf = n_ferr;
        u_if.ready = 1'b1;
        send_byte(8'h4F, 1'b1);
        t0 = cyc;
        send_byte(8'h3E, 1'b1);
        idle_bits(2);
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL basic_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'h4f3e) begin failures++; $display("FAIL basic_word got=%h exp=4f3e", words[bw]); end
        checks++; if (n_vrise - bv !== 1) begin failures++; $display("FAIL basic_vrise got=%0d exp=1", n_vrise - bv); end
        checks++; if (u_if.valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", u_if.valid); end
        checks++; if (n_ferr - bf !== 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", n_ferr - bf); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
`ifdef UART_RX_PARITY_EN
        nom = 2 + BIT / 2 + 10 * BIT + 1;
`else
        nom = 2 + BIT / 2 + 9 * BIT + 1;
`endif
        lat = t_rise - t0;
        checks++; if (lat < nom - 2 || lat > nom + 3) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, nom); end
    endtask

    task automatic test_glitch();
        int bw, bf;
        bw = n_words; bf = n_ferr;
        uart_rx = 1'b0;
        repeat (4) tick();
        idle_bits(2);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle_bits(2);
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL glitch_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'h1234) begin failures++; $display("FAIL glitch_word got=%h exp=1234", words[bw]); end
        checks++; if (n_ferr - bf !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr - bf); end
    endtask

    task automatic test_frame_err();
        int bw, bf;
        bw = n_words; bf = n_ferr;
        send_byte(8'hAA, 1'b0);
        idle_bits(2);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        idle_bits(2);
        checks++; if (n_ferr - bf !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - bf); end
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL ferr_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'h5566) begin failures++; $display("FAIL ferr_word got=%h exp=5566", words[bw]); end
        // Bad low byte discards the stored high byte
        bw = n_words; bf = n_ferr;
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b0);
        idle_bits(2);
        send_byte(8'h99, 1'b1);
        send_byte(8'hAA, 1'b1);
        idle_bits(2);
        checks++; if (n_ferr - bf !== 1) begin failures++; $display("FAIL ferr_p1_count got=%0d exp=1", n_ferr - bf); end
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL ferr_p1_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'h99aa) begin failures++; $display("FAIL ferr_p1_word got=%h exp=99aa", words[bw]); end
    endtask

    task automatic test_timeout();
        int bw, bf;
        bw = n_words; bf = n_ferr;
        send_byte(8'h01, 1'b1);
        idle_bits(25);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        idle_bits(2);
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL timeout_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'h0203) begin failures++; $display("FAIL timeout_word got=%h exp=0203", words[bw]); end
        checks++; if (n_ferr - bf !== 0) begin failures++; $display("FAIL timeout_ferr got=%0d exp=0", n_ferr - bf); end
        // A gap shorter than the timeout keeps the high byte
        bw = n_words;
        send_byte(8'h05, 1'b1);
        idle_bits(10);
        send_byte(8'h06, 1'b1);
        idle_bits(2);
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL short_gap_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'h0506) begin failures++; $display("FAIL short_gap_word got=%h exp=0506", words[bw]); end
    endtask

    task automatic test_overrun();
        int bw, bv;
        bw = n_words; bv = n_vrise;
        u_if.ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h11, 1'b1);
        idle_bits(2);
        send_byte(8'h22, 1'b1);
        send_byte(8'h22, 1'b1);
        idle_bits(3);
        checks++; if (u_if.valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held got=%b exp=1", u_if.valid); end
        checks++; if (u_if.data !== 16'h1111) begin failures++; $display("FAIL ovr_data_held got=%h exp=1111", u_if.data); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (n_words - bw !== 0) begin failures++; $display("FAIL ovr_no_accept got=%0d exp=0", n_words - bw); end
        u_if.ready = 1'b1;
        idle_bits(3);
        checks++; if (u_if.valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_drop got=%b exp=0", u_if.valid); end
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL ovr_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'h1111) begin failures++; $display("FAIL ovr_word got=%h exp=1111", words[bw]); end
        checks++; if (n_vrise - bv !== 1) begin failures++; $display("FAIL ovr_no_reassert got=%0d exp=1", n_vrise - bv); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_reset_mid();
        int bw;
        send_byte(8'hAB, 1'b1);
        // Low byte: start bit, bits 0..2, then half of bit 3
        uart_rx = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < 3; i++) begin
            uart_rx = 1'b1;
            repeat (BIT) tick();
        end
        uart_rx = 1'b0;
        repeat (BIT / 2) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (u_if.data !== 16'h0000) begin failures++; $display("FAIL rstmid_data got=%h exp=0000", u_if.data); end
        checks++; if (u_if.valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", u_if.valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
        repeat (4) tick();
        uart_rx = 1'b1;
        repeat (4) tick();
        rst_n = 1'b1;
        idle_bits(2);
        bw = n_words;
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle_bits(2);
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL rstmid_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'hbeef) begin failures++; $display("FAIL rstmid_word got=%h exp=beef", words[bw]); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_byte_badpar(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) tick();
        end
        uart_rx = ~(^b);
        repeat (BIT) tick();
        uart_rx = 1'b1;
        repeat (BIT) tick();
    endtask

    task automatic test_parity();
        int bw, bf;
        bw = n_words; bf = n_ferr;
        send_byte_badpar(8'h07);
        send_byte(8'h07, 1'b1);
        send_byte(8'h08, 1'b1);
        idle_bits(2);
        checks++; if (n_ferr - bf !== 1) begin failures++; $display("FAIL parity_ferr got=%0d exp=1", n_ferr - bf); end
        checks++; if (n_words - bw !== 1) begin failures++; $display("FAIL parity_nwords got=%0d exp=1", n_words - bw); end
        checks++; if (words[bw] !== 16'h0708) begin failures++; $display("FAIL parity_word got=%h exp=0708", words[bw]); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_timeout();
        test_overrun();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
